qspi_psram_target: RTL and testbench

- Synthesizable QSPI PSRAM responder. It is the target-side counterpart of the SpiBus initiator and serves as the on-chip stand-in for the tangnano PSRAM in loopback builds and benches.
- It oversamples sclk/ce in the system_clock domain, decodes serial (1-bit) and quad (4-bit) command frames, and serves byte reads/writes from an internal RAM array.
- It tracks SPI/QPI mode exactly as the external device does.

---
 rtl/qspi_psram_target.sv | 251 +++++++++++++++++++++++++
 tb/tb_qspi_psram_target.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_psram_target.sv
// QSPI PSRAM responder: oversampled serial/quad command decode serving byte reads/writes from internal RAM.
// Optional 0x9F read-ID support is built when QSPI_PSRAM_TARGET_READ_ID_EN is defined.
module qspi_psram_target #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic       system_clock,
    input  logic       reset_n,
    input  logic       sclk,
    input  logic       ce,
    input  logic [3:0] sio_in,
    output logic [3:0] sio_out,
    output logic [3:0] sio_oe,
    output logic       quad_mode,
    output logic       busy
);
    localparam int AW     = $clog2(DEPTH);
    localparam int SW     = (AW > 8) ? AW : 8;
    localparam int WAIT_W = $clog2(WAIT_CYCLES + 1);
    localparam int CNT_W  = (WAIT_W > 5) ? WAIT_W : 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WAIT,
        ST_RD_SER,
        ST_RD_QUAD,
        ST_WR_SER,
        ST_WR_QUAD,
        ST_IGNORE
`ifdef QSPI_PSRAM_TARGET_READ_ID_EN
        , ST_ID
`endif
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ce_sync;
    logic [3:0]             r_sio_sync [SYNC_STAGES];
    logic                   r_sclk_d;
    logic                   r_ce_d;

    state_t                 r_state;
    state_t                 r_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [SW-1:0]          r_shift;
    logic [AW-1:0]          r_ptr;
    logic                   r_addr_quad;
    logic [7:0]             r_mem [DEPTH];

    logic                   w_sclk_s;
    logic                   w_ce_s;
    logic [3:0]             w_sio_s;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_ce_rise;
    logic                   w_ce_fall;
    logic                   w_lane_quad;
    logic [SW-1:0]          w_shift_next;
    logic                   w_mem_we;
    logic [7:0]             w_mem_q;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ce_s      = r_ce_sync[SYNC_STAGES-1];
    assign w_sio_s     = r_sio_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_ce_rise   = w_ce_s & ~r_ce_d;
    assign w_ce_fall   = ~w_ce_s & r_ce_d;
    assign w_mem_q     = r_mem[r_ptr];

`ifdef QSPI_PSRAM_TARGET_READ_ID_EN
    logic [1:0] r_id_idx;
    logic [7:0] w_id_byte;
    assign w_id_byte = (r_id_idx == 2'd0) ? 8'h0D :
                       (r_id_idx == 2'd1) ? 8'h5D : 8'h00;
`endif

    // ce resets to its idle (high) level so reset release never looks like a frame start.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= '0;
            r_ce_sync   <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) r_sio_sync[i] <= '0;
            r_sclk_d    <= 1'b0;
            r_ce_d      <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every stage sample its predecessor's old value, forming a true shift chain.
            r_sclk_sync[0] <= sclk;
            r_ce_sync[0]   <= ce;
            r_sio_sync[0]  <= sio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sclk_sync[i] <= r_sclk_sync[i-1];
                r_ce_sync[i]   <= r_ce_sync[i-1];
                r_sio_sync[i]  <= r_sio_sync[i-1];
            end
            r_sclk_d <= w_sclk_s;
            r_ce_d   <= w_ce_s;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_lane_quad = 1'b0;
        w_mem_we    = 1'b0;
        case (r_state)
            ST_CMD:     w_lane_quad = quad_mode;
            ST_ADDR:    w_lane_quad = r_addr_quad;
            ST_WR_QUAD: w_lane_quad = 1'b1;
            default:    w_lane_quad = 1'b0;
        endcase
        w_shift_next = w_lane_quad ? {r_shift[SW-5:0], w_sio_s} : {r_shift[SW-2:0], w_sio_s[0]};
        if (w_sclk_rise && !w_ce_rise && !w_ce_fall) begin
            w_mem_we = ((r_state == ST_WR_SER)  && (r_cnt == CNT_W'(7))) ||
                       ((r_state == ST_WR_QUAD) && (r_cnt == CNT_W'(1)));
        end
    end

    // NOTE: RAM has no reset so it maps onto plain memory; its contents are undefined after reset.
    always_ff @(posedge system_clock) begin
        if (w_mem_we) r_mem[r_ptr] <= w_shift_next[7:0];
    end

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_next      <= ST_IGNORE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_ptr       <= '0;
            r_addr_quad <= 1'b0;
            sio_out     <= '0;
            sio_oe      <= '0;
            quad_mode   <= 1'b0;
            busy        <= 1'b0;
`ifdef QSPI_PSRAM_TARGET_READ_ID_EN
            r_id_idx    <= '0;
`endif
        end else if (w_ce_rise) begin
            r_state <= ST_IDLE;
            sio_oe  <= '0;
            sio_out <= '0;
            busy    <= 1'b0;
        end else if (w_ce_fall) begin
            r_state <= ST_CMD;
            r_cnt   <= '0;
            sio_oe  <= '0;
            sio_out <= '0;
            busy    <= 1'b1;
`ifdef QSPI_PSRAM_TARGET_READ_ID_EN
            r_id_idx <= '0;
`endif
        end else if (w_sclk_rise) begin
            case (r_state)
                ST_CMD: begin
                    r_shift <= w_shift_next;
                    if (r_cnt == (quad_mode ? CNT_W'(1) : CNT_W'(7))) begin
                        r_cnt   <= '0;
                        r_state <= ST_IGNORE;
                        case (w_shift_next[7:0])
                            8'h03: if (!quad_mode) begin
                                r_state <= ST_ADDR; r_addr_quad <= 1'b0; r_next <= ST_RD_SER;
                            end
                            8'h02: if (!quad_mode) begin
                                r_state <= ST_ADDR; r_addr_quad <= 1'b0; r_next <= ST_WR_SER;
                            end
                            8'hEB: begin
                                r_state <= ST_ADDR; r_addr_quad <= 1'b1; r_next <= ST_WAIT;
                            end
                            8'h38: begin
                                r_state <= ST_ADDR; r_addr_quad <= 1'b1; r_next <= ST_WR_QUAD;
                            end
                            8'h35: quad_mode <= 1'b1;
                            8'hF5: quad_mode <= 1'b0;
`ifdef QSPI_PSRAM_TARGET_READ_ID_EN
                            8'h9F: if (!quad_mode) begin
                                r_state <= ST_ADDR; r_addr_quad <= 1'b0; r_next <= ST_ID;
                            end
`endif
                            default: ;
                        endcase
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_ADDR: begin
                    r_shift <= w_shift_next;
                    if (r_cnt == (r_addr_quad ? CNT_W'(5) : CNT_W'(23))) begin
                        r_cnt <= '0;
                        r_ptr <= w_shift_next[AW-1:0];
                        if (r_next == ST_WAIT && WAIT_CYCLES == 0) r_state <= ST_RD_QUAD;
                        else                                     r_state <= r_next;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == CNT_W'(WAIT_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_RD_QUAD;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WR_SER, ST_WR_QUAD: begin
                    r_shift <= w_shift_next;
                    if (w_mem_we) begin
                        r_cnt <= '0;
                        r_ptr <= r_ptr + AW'(1);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end else if (w_sclk_fall) begin
            case (r_state)
                ST_RD_SER: begin
                    sio_oe  <= 4'b0010;
                    sio_out <= {2'b00, w_mem_q[3'd7 - r_cnt[2:0]], 1'b0};
                    if (r_cnt == CNT_W'(7)) begin
                        r_cnt <= '0;
                        r_ptr <= r_ptr + AW'(1);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RD_QUAD: begin
                    sio_oe  <= 4'b1111;
                    sio_out <= r_cnt[0] ? w_mem_q[3:0] : w_mem_q[7:4];
                    if (r_cnt[0]) r_ptr <= r_ptr + AW'(1);
                    r_cnt <= r_cnt[0] ? '0 : CNT_W'(1);
                end
`ifdef QSPI_PSRAM_TARGET_READ_ID_EN
                ST_ID: begin
                    sio_oe  <= 4'b0010;
                    sio_out <= {2'b00, w_id_byte[3'd7 - r_cnt[2:0]], 1'b0};
                    if (r_cnt == CNT_W'(7)) begin
                        r_cnt <= '0;
                        if (r_id_idx != 2'd2) r_id_idx <= r_id_idx + 2'd1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_qspi_psram_target.sv
// Self-checking bench for qspi_psram_target: directed frames plus randomized read/write traffic vs. a byte-array model.
// Follows QSPI_PSRAM_TARGET_READ_ID_EN to choose the 0x9F expectation.
module tb_qspi_psram_target;
    localparam int DEPTH       = 1024;
    localparam int WAIT_CYCLES = 6;
    localparam int HALF        = 6;

    logic       system_clock = 1'b0;
    logic       reset_n      = 1'b0;
    logic       sclk         = 1'b0;
    logic       ce           = 1'b1;
    logic [3:0] sio_in       = 4'h0;
    logic [3:0] sio_out;
    logic [3:0] sio_oe;
    logic       quad_mode;
    logic       busy;

    qspi_psram_target #(
        .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES), .SYNC_STAGES(2)
    ) dut (
        .system_clock(system_clock), .reset_n(reset_n), .sclk(sclk), .ce(ce),
        .sio_in(sio_in), .sio_out(sio_out), .sio_oe(sio_oe),
        .quad_mode(quad_mode), .busy(busy)
    );

    always #5 system_clock = ~system_clock;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] model_mem [DEPTH];
    bit         model_ok  [DEPTH];
    logic [7:0] wbuf [8];
    logic [7:0] rbuf [8];
    logic [3:0] oe_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge system_clock);
    endtask

    // One sclk period: drive data while low, sample the target just before the rise.
    task automatic xfer(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
        sio_in = d;
        wait_clk(HALF);
        q  = sio_out;
        oe = sio_oe;
        sclk = 1'b1;
        wait_clk(HALF);
        sclk = 1'b0;
    endtask

    task automatic tx_bits(input logic [23:0] v, input int nbits, input bit quad);
        logic [3:0] q, oe;
        if (quad) begin
            for (int i = 0; i < nbits / 4; i++) begin
                xfer(v[nbits-1-4*i -: 4], q, oe);
                oe_acc |= oe;
            end
        end else begin
            for (int i = 0; i < nbits; i++) begin
                xfer({3'b000, v[nbits-1-i]}, q, oe);
                oe_acc |= oe;
            end
        end
    endtask

    task automatic tx_byte(input logic [7:0] b, input bit quad);
        tx_bits({16'h0000, b}, 8, quad);
    endtask

    task automatic rx_bytes(input int n, input bit quad);
        logic [3:0] q, oe, exp_oe, oe_seen;
        logic [7:0] b;
        exp_oe = quad ? 4'b1111 : 4'b0010;
        for (int k = 0; k < n; k++) begin
            b = 8'h00;
            oe_seen = exp_oe;
            for (int i = 0; i < (quad ? 2 : 8); i++) begin
                xfer(4'h0, q, oe);
                if (oe !== exp_oe) oe_seen = oe;
                b = quad ? {b[3:0], q} : {b[6:0], q[1]};
            end
            rbuf[k] = b;
            check("rd_oe", oe_seen, exp_oe);
        end
    endtask

    task automatic frame_begin();
        sclk = 1'b0;
        ce   = 1'b0;
        wait_clk(HALF);
        oe_acc = 4'h0;
        check("busy_hi", busy, 1);
    endtask

    task automatic frame_end();
        wait_clk(HALF);
        ce = 1'b1;
        wait_clk(HALF);
        check("oe_off", sio_oe, 0);
        check("busy_lo", busy, 0);
    endtask

    task automatic set_qpi(input bit on);
        frame_begin();
        tx_byte(on ? 8'h35 : 8'hF5, quad_mode);
        frame_end();
        check("quad_mode", quad_mode, on);
    endtask

    task automatic write_frame(input bit qpi, input bit quad, input logic [23:0] addr, input int n);
        frame_begin();
        tx_byte(quad ? 8'h38 : 8'h02, qpi);
        tx_bits(addr, 24, quad);
        for (int i = 0; i < n; i++) tx_byte(wbuf[i], quad);
        check("wr_oe", oe_acc, 0);
        frame_end();
        for (int i = 0; i < n; i++) begin
            model_mem[(int'(addr) + i) % DEPTH] = wbuf[i];
            model_ok[(int'(addr) + i) % DEPTH]  = 1'b1;
        end
    endtask

    task automatic read_frame(input bit qpi, input bit quad, input logic [23:0] addr, input int n);
        logic [3:0] q, oe;
        int a;
        frame_begin();
        tx_byte(quad ? 8'hEB : 8'h03, qpi);
        tx_bits(addr, 24, quad);
        if (quad) begin
            for (int i = 0; i < WAIT_CYCLES; i++) begin
                xfer(4'h0, q, oe);
                oe_acc |= oe;
            end
        end
        check("pre_oe", oe_acc, 0);
        rx_bytes(n, quad);
        frame_end();
        for (int i = 0; i < n; i++) begin
            a = (int'(addr) + i) % DEPTH;
            if (model_ok[a]) check("rd_data", rbuf[i], model_mem[a]);
        end
    endtask

    initial begin
        logic [3:0]  q, oe;
        logic [23:0] addr;
        bit          qpi, wq, rq;
        int          n;

        for (int i = 0; i < DEPTH; i++) model_ok[i] = 1'b0;

        wait_clk(3);
        check("rst_oe", sio_oe, 0);
        check("rst_out", sio_out, 0);
        check("rst_qm", quad_mode, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        wait_clk(4);

        // Serial write then serial read back.
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        write_frame(0, 0, 24'h000010, 2);
        read_frame(0, 0, 24'h000010, 2);

        // Quad write, quad read from an offset.
        wbuf[0] = 8'h12; wbuf[1] = 8'h34; wbuf[2] = 8'h56;
        write_frame(0, 1, 24'h000100, 3);
        read_frame(0, 1, 24'h000101, 2);

        // Aborted write: only the completed byte lands.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        write_frame(0, 0, 24'h000020, 2);
        frame_begin();
        tx_byte(8'h02, 0);
        tx_bits(24'h000020, 24, 0);
        tx_byte(8'hFF, 0);
        for (int i = 0; i < 4; i++) xfer(4'h0, q, oe);
        frame_end();
        model_mem[32'h20] = 8'hFF;
        read_frame(0, 0, 24'h000020, 2);

        // QPI mode: quad commands accepted, serial read ignored.
        set_qpi(1);
        read_frame(1, 1, 24'h000010, 2);
        frame_begin();
        tx_byte(8'h03, 1);
        tx_bits(24'h000010, 24, 1);
        for (int i = 0; i < 8; i++) begin
            xfer(4'h0, q, oe);
            oe_acc |= oe;
        end
        check("ign_oe", oe_acc, 0);
        frame_end();
        set_qpi(0);

        // Wrap-around at the top of the array.
        wbuf[0] = 8'h01; wbuf[1] = 8'h02;
        write_frame(0, 0, 24'(DEPTH - 1), 2);
        read_frame(0, 0, 24'h000000, 1);
        read_frame(0, 1, 24'(DEPTH - 1), 2);

        // Randomized traffic; upper address bits must alias modulo DEPTH.
        for (int it = 0; it < 12; it++) begin
            qpi  = 1'($urandom_range(0, 1));
            wq   = qpi ? 1'b1 : 1'($urandom_range(0, 1));
            rq   = qpi ? 1'b1 : 1'($urandom_range(0, 1));
            addr = 24'($urandom);
            n    = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            if (qpi) set_qpi(1);
            write_frame(qpi, wq, addr, n);
            read_frame(qpi, rq, addr, n);
            if (qpi) set_qpi(0);
        end

        // Reset in the middle of a QPI quad read.
        set_qpi(1);
        frame_begin();
        tx_byte(8'hEB, 1);
        tx_bits(24'h000100, 24, 1);
        for (int i = 0; i < WAIT_CYCLES; i++) xfer(4'h0, q, oe);
        rx_bytes(1, 1);
        check("rst_rd_data", rbuf[0], model_mem[32'h100]);
        xfer(4'h0, q, oe);
        wait_clk(HALF);
        check("pre_rst_oe", sio_oe, 4'b1111);
        reset_n = 1'b0;
        #1;
        check("arst_oe", sio_oe, 0);
        check("arst_qm", quad_mode, 0);
        ce   = 1'b1;
        sclk = 1'b0;
        wait_clk(4);
        reset_n = 1'b1;
        wait_clk(4);
        for (int i = 0; i < DEPTH; i++) model_ok[i] = 1'b0;

        // Read-ID opcode.
        frame_begin();
        tx_byte(8'h9F, 0);
        tx_bits(24'h000000, 24, 0);
`ifdef QSPI_PSRAM_TARGET_READ_ID_EN
        check("id_pre_oe", oe_acc, 0);
        rx_bytes(3, 0);
        check("id_mfid", rbuf[0], 8'h0D);
        check("id_kgd", rbuf[1], 8'h5D);
        check("id_pad", rbuf[2], 8'h00);
`else
        for (int i = 0; i < 16; i++) begin
            xfer(4'h0, q, oe);
            oe_acc |= oe;
        end
        check("id_oe", oe_acc, 0);
`endif
        frame_end();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
